// File: rtl/tt_um_akaur_logic_checker.sv
// Stimulus/check end for the 3-input logic cell: sweeps {C,B,A}, samples x/y, reports pass/fail and err count.
// Optional LOGIC_CHECKER_LOOPBACK_EN replaces the returned pins with an internal golden cell for self-test.
module tt_um_akaur_logic_checker #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // Out-of-range settings are clamped so the counter width and the sync latency stay valid.
   localparam int unsigned SETTLE_EFF =
      (SETTLE_CYCLES < 3) ? 3 : ((SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_EFF - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] work_err_q, work_err_d;
   logic [3:0] err_cnt_q, err_cnt_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic       fail_q, fail_d;

   logic       start_meta_q, start_sync_q, start_prev_q;
   logic [1:0] ret_meta_q, ret_sync_q;
   logic [1:0] ret_raw;
   logic       start_edge;
   logic       busy;
   logic       exp_x, exp_y, mismatch;
   logic       unused_inputs;

`ifdef LOGIC_CHECKER_LOOPBACK_EN
   logic lb_x, lb_y;
   assign lb_x          = (uio_out[0] & uio_out[1]) | ~uio_out[2];
   assign lb_y          = ~uio_out[2];
   assign ret_raw       = {lb_y, lb_x};
   assign unused_inputs = ^{ena, ui_in[7:2], uio_in};
`else
   assign ret_raw       = uio_in[4:3];
   assign unused_inputs = ^{ena, ui_in[7:2], uio_in[7:5], uio_in[2:0]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_meta_q <= 1'b0;
         start_sync_q <= 1'b0;
         start_prev_q <= 1'b0;
         ret_meta_q   <= 2'b00;
         ret_sync_q   <= 2'b00;
      end else begin
         start_meta_q <= ui_in[0];
         start_sync_q <= start_meta_q;
         start_prev_q <= start_sync_q;
         ret_meta_q   <= ret_raw;
         ret_sync_q   <= ret_meta_q;
      end
   end

   assign start_edge = start_sync_q & ~start_prev_q;
   assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

   assign exp_x    = (idx_q[0] & idx_q[1]) | ~idx_q[2];
   assign exp_y    = ~idx_q[2];
   assign mismatch = (ret_sync_q[0] != exp_x) || (ret_sync_q[1] != exp_y);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= 3'd0;
         cnt_q      <= 4'd0;
         work_err_q <= 4'd0;
         err_cnt_q  <= 4'd0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         work_err_q <= work_err_d;
         err_cnt_q  <= err_cnt_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      work_err_d = work_err_q;
      err_cnt_d  = err_cnt_q;
      done_d     = done_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               idx_d      = 3'd0;
               cnt_d      = 4'd0;
               work_err_d = 4'd0;
               state_d    = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = 4'd0;
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_SAMPLE: begin
            work_err_d = work_err_q + {3'b000, mismatch};
            if (idx_q == 3'd7) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = ST_SETTLE;
            end
         end
         ST_DONE: begin
            // Results only change here, so continuous mode never shows a half-finished sweep.
            err_cnt_d  = work_err_q;
            pass_d     = (work_err_q == 4'd0);
            fail_d     = (work_err_q != 4'd0);
            done_d     = 1'b1;
            idx_d      = 3'd0;
            cnt_d      = 4'd0;
            work_err_d = 4'd0;
            state_d    = ui_in[1] ? ST_SETTLE : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign uo_out  = {err_cnt_q, fail_q, pass_q, done_q, busy};
   assign uio_out = {5'b00000, idx_q};
   assign uio_oe  = 8'b0000_0111;

endmodule

// File: tb/tb_tt_um_akaur_logic_checker.sv
// Bench for tt_um_akaur_logic_checker: external logic-cell model with stuck-at faults and a result scoreboard.
// Build with LOGIC_CHECKER_LOOPBACK_EN to exercise the internal self-test path.
module tb_tt_um_akaur_logic_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   logic x_stuck0 = 1'b0;
   logic y_stuck1 = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   tt_um_akaur_logic_checker dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

`ifdef LOGIC_CHECKER_LOOPBACK_EN
   assign uio_in = 8'hFF;
`else
   // External logic cell, optionally with a stuck-at fault on either output.
   assign uio_in = {3'b000,
                    y_stuck1 ? 1'b1 : ~uio_out[2],
                    x_stuck0 ? 1'b0 : ((uio_out[0] & uio_out[1]) | ~uio_out[2]),
                    3'b000};
`endif

   function automatic bit vec_mismatch(input int v, input bit sx0, input bit sy1);
      logic [7:0] gold_x;
      logic [7:0] gold_y;
      gold_x = 8'b1000_1111;
      gold_y = 8'b0000_1111;
`ifdef LOGIC_CHECKER_LOOPBACK_EN
      return 1'b0;
`else
      return (sx0 && gold_x[v]) || (sy1 && !gold_y[v]);
`endif
   endfunction

   task automatic test_reset();
      rst_n = 1'b1;
      ui_in = 8'h00;
      ena   = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (uo_out !== 8'h00) begin
         n_err++; $display("FAIL reset uo_out: got %h expected 00", uo_out);
      end
      n_cmp++;
      if (uio_out !== 8'h00) begin
         n_err++; $display("FAIL reset uio_out: got %h expected 00", uio_out);
      end
      n_cmp++;
      if (uio_oe !== 8'h07) begin
         n_err++; $display("FAIL reset uio_oe: got %h expected 07", uio_oe);
      end
      $display("reset: uo_out=%h uio_out=%h uio_oe=%h", uo_out, uio_out, uio_oe);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle();
      bit ok;
      ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (uo_out !== 8'h00) ok = 1'b0;
      end
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL idle: uo_out=%h expected 00 without start", uo_out);
      end else $display("idle: uo_out stays 00 without start");
   endtask

   task automatic start_sweep(input string name);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      ui_in[0] = 1'b1;
      while (!seen && n < 8) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (uo_out[0] === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen || n != 3) begin
         n_err++; $display("FAIL %s start latency: got %0d edges (busy=%b) expected 3", name, n, uo_out[0]);
      end else $display("%s: busy after %0d edges", name, n);
      ui_in[0] = 1'b0;
   endtask

   // Called at the first negedge of vector 0; returns at the negedge after the DONE cycle.
   task automatic follow_sweep(input string name, input int inject_at, input bit inj_x0,
                               input bit inj_y1, input bit poke_start, input bit hold_done,
                               input bit busy_after, input int clear_cont_at);
      int   err;
      bit   seq_ok, hold_ok;
      logic [7:0] e, got;
      err = 0;
      seq_ok = 1'b1;
      hold_ok = 1'b1;
      for (int v = 0; v < 8; v++) begin
         for (int k = 0; k < 5; k++) begin
            if (k == 0 && v == inject_at) begin
               x_stuck0 = inj_x0;
               y_stuck1 = inj_y1;
            end
            if (k == 0 && v == clear_cont_at) ui_in[1] = 1'b0;
            if (k == 0 && vec_mismatch(v, x_stuck0, y_stuck1)) err++;
            if (poke_start && v == 2 && k == 1) ui_in[0] = 1'b1;
            if (poke_start && v == 2 && k == 3) ui_in[0] = 1'b0;
            if (uio_out !== 8'(v) || uo_out[0] !== 1'b1) seq_ok = 1'b0;
            if (hold_done && uo_out[1] !== 1'b1) hold_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
         end
      end
      e = {4'(err), (err != 0), (err == 0), 1'b1, busy_after};
      exp_q.push_back(e);
      n_cmp++;
      if (!seq_ok) begin
         n_err++; $display("FAIL %s vectors: sequence/hold broken, last uio_out=%h", name, uio_out);
      end
      if (hold_done) begin
         n_cmp++;
         if (!hold_ok) begin
            n_err++; $display("FAIL %s done hold: done dropped during sweep, uo_out=%h", name, uo_out);
         end
      end
      n_cmp++;
      if (uo_out[0] !== 1'b0) begin
         n_err++; $display("FAIL %s done-cycle busy: got %b expected 0", name, uo_out[0]);
      end
      @(posedge clk);
      @(negedge clk);
      got = uo_out;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++; $display("FAIL %s result: scoreboard empty, uo_out=%h", name, got);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            n_err++; $display("FAIL %s result: uo_out=%h expected %h", name, got, e);
         end else $display("%s: uo_out=%h err_cnt=%0d", name, got, err);
      end
   endtask

   task automatic check_hold(input string name, input logic [7:0] e);
      bit ok;
      ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (uo_out !== e) ok = 1'b0;
      end
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL %s hold: uo_out=%h expected %h", name, uo_out, e);
      end else $display("%s: result %h held while idle", name, e);
   endtask

   task automatic test_ideal_oneshot();
      start_sweep("ideal");
      follow_sweep("ideal", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      check_hold("ideal", 8'h06);
   endtask

   task automatic test_x_stuck0();
      x_stuck0 = 1'b1;
      start_sweep("x_stuck0");
      follow_sweep("x_stuck0", -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      x_stuck0 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_y_stuck1();
      y_stuck1 = 1'b1;
      start_sweep("y_stuck1");
      follow_sweep("y_stuck1", -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      y_stuck1 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_continuous();
      logic [7:0] last_e;
      ui_in[1] = 1'b1;
      start_sweep("cont");
      follow_sweep("cont_sweep1", -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
      follow_sweep("cont_sweep2", 4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1);
      follow_sweep("cont_sweep3", -1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
      follow_sweep("cont_last", -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
`ifdef LOGIC_CHECKER_LOOPBACK_EN
      last_e = 8'h06;
`else
      last_e = 8'h5A;
`endif
      check_hold("cont_stop", last_e);
      x_stuck0 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_sweep();
      bit found;
      found = 1'b0;
      start_sweep("mid_reset");
      for (int i = 0; i < 40 && !found; i++) begin
         if (uio_out[2:0] == 3'd3) found = 1'b1;
         else begin
            @(posedge clk);
            @(negedge clk);
         end
      end
      n_cmp++;
      if (!found) begin
         n_err++; $display("FAIL mid_reset reach idx3: uio_out=%h expected 03 within 40 cycles", uio_out);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         n_err++; $display("FAIL mid_reset outputs: uo_out=%h uio_out=%h expected 00/00", uo_out, uio_out);
      end else $display("mid_reset: outputs cleared immediately");
      n_cmp++;
      if (uio_oe !== 8'h07) begin
         n_err++; $display("FAIL mid_reset uio_oe: got %h expected 07", uio_oe);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      start_sweep("after_reset");
      follow_sweep("after_reset", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
   endtask

   initial begin
      ena = 1'b1;
      ui_in = 8'h00;
      test_reset();
      test_idle();
      test_ideal_oneshot();
      test_x_stuck0();
      test_y_stuck1();
      test_continuous();
      test_reset_mid_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
